screen_controller: RTL

Top-level screen sequencer that sits directly upstream of the game-over screen drawer. It also sequences the title and gameplay drawers.
- Issues level go to exactly one screen drawer at a time.
- Watches each drawer's done and advances the game state.
- Muxes the active drawer's pixel stream into one registered x/y/color/plot stream for the VGA adapter.
- Generates the 60 Hz frame tick that the drawers' frame counters consume.

---
 rtl/screen_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/screen_controller.sv
// rtl/screen_controller.sv - screen sequencer: drawer go/done handshake, pixel mux, frame tick
// Optional SCREEN_TIMEOUT_EN: forced exit from OVER after TIMEOUT_FRAMES frame ticks.
module screen_controller #(
  parameter int CLK_DIV        = 833333,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_key,
  input  logic       player_dead,
  input  logic       title_done,
  input  logic       over_done,
  input  logic [8:0] title_x,
  input  logic [8:0] play_x,
  input  logic [8:0] over_x,
  input  logic [7:0] title_y,
  input  logic [7:0] play_y,
  input  logic [7:0] over_y,
  input  logic [2:0] title_color,
  input  logic [2:0] play_color,
  input  logic [2:0] over_color,
  input  logic       title_plot,
  input  logic       play_plot,
  input  logic       over_plot,
  output logic       title_go,
  output logic       play_go,
  output logic       over_go,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       frame_tick,
  output logic [2:0] state_out
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    TITLE    = 3'd0,
    TO_PLAY  = 3'd1,
    PLAY     = 3'd2,
    TO_OVER  = 3'd3,
    OVER     = 3'd4,
    TO_TITLE = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_div;
  logic          w_timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div      <= '0;
      frame_tick <= 1'b0;
    end else if (r_div == CW'(CLK_DIV - 1)) begin
      r_div      <= '0;
      frame_tick <= 1'b1;
    end else begin
      r_div      <= r_div + 1'b1;
      frame_tick <= 1'b0;
    end
  end

`ifdef SCREEN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  logic [TW-1:0] r_to_cnt;

  // The tick that brings the count to TIMEOUT_FRAMES triggers the exit on the same edge.
  assign w_timeout = frame_tick && (r_to_cnt == TW'(TIMEOUT_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || r_state != OVER)
      r_to_cnt <= '0;
    else if (frame_tick && r_to_cnt != TW'(TIMEOUT_FRAMES))
      r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= TITLE;
    end else begin
      case (r_state)
        TITLE:    if (title_done && start_key) r_state <= TO_PLAY;
        TO_PLAY:  r_state <= PLAY;
        PLAY:     if (player_dead) r_state <= TO_OVER;
        TO_OVER:  r_state <= OVER;
        OVER:     if (over_done || w_timeout) r_state <= TO_TITLE;
        TO_TITLE: r_state <= TITLE;
        default:  r_state <= TITLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x     <= '0;
      y     <= '0;
      color <= '0;
      plot  <= 1'b0;
    end else begin
      case (r_state)
        TITLE: begin
          x     <= title_x;
          y     <= title_y;
          color <= title_color;
          plot  <= title_plot;
        end
        PLAY: begin
          x     <= play_x;
          y     <= play_y;
          color <= play_color;
          plot  <= play_plot;
        end
        OVER: begin
          x     <= over_x;
          y     <= over_y;
          color <= over_color;
          plot  <= over_plot;
        end
        default: plot <= 1'b0;
      endcase
    end
  end

  assign title_go  = (r_state == TITLE);
  assign play_go   = (r_state == PLAY);
  assign over_go   = (r_state == OVER);
  assign state_out = r_state;

endmodule
